// File: rtl/sbox1x2_buffered_if.sv
// Stream bundle for the 1-to-2 switching box: one input stream, two output
// streams, the route request and the busy flag.
interface sbox1x2_buffered_if #(parameter int SIZE = 32);
  logic [SIZE-1:0] in1_data;
  logic            in1_write;
  logic            in1_full_n;
  logic [SIZE-1:0] out1_data;
  logic            out1_write;
  logic            out1_full_n;
  logic [SIZE-1:0] out2_data;
  logic            out2_write;
  logic            out2_full_n;
  logic            sel;
  logic            busy;

  // Driving side: producer, both consumers and the route controller.
  modport master (
    output in1_data, in1_write, out1_full_n, out2_full_n, sel,
    input  in1_full_n, out1_data, out1_write, out2_data, out2_write, busy
  );

  // The switching box itself.
  modport slave (
    input  in1_data, in1_write, out1_full_n, out2_full_n, sel,
    output in1_full_n, out1_data, out1_write, out2_data, out2_write, busy
  );
endinterface

// File: rtl/sbox1x2_buffered.sv
// Registered 1-to-2 switching box with a 2-entry elastic buffer. A route
// change first drains the buffer on the old route, then flips the route.
module sbox1x2_buffered #(
  parameter int SIZE = 32
) (
  input logic                clock,
  input logic                reset,
  sbox1x2_buffered_if.slave  bus
);

  localparam logic [0:0] ACTIVE = 1'b0;
  localparam logic [0:0] DRAIN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [1:0]      count_q, count_d;
  logic            route_q, route_d;
  logic [SIZE-1:0] mem0_q, mem0_d;   // head of the FIFO
  logic [SIZE-1:0] mem1_q, mem1_d;   // second entry

  logic nonempty, match, accept, push, pop, routed_ready;

  assign nonempty     = (count_q != 2'd0);
  assign match        = (bus.sel == route_q);
  assign routed_ready = route_q ? bus.out2_full_n : bus.out1_full_n;

  // Acceptance depends only on registered state and sel, never on the
  // consumers' full_n, so there is no ready path through the block.
  assign accept = reset && (state_q == ACTIVE) && (count_q != 2'd2) && match;
  assign push   = bus.in1_write && accept;
  assign pop    = reset && nonempty && routed_ready;

  assign bus.in1_full_n = accept;
  assign bus.out1_write = reset && nonempty && !route_q;
  assign bus.out2_write = reset && nonempty &&  route_q;
  assign bus.out1_data  = nonempty ? mem0_q : '0;
  assign bus.out2_data  = nonempty ? mem0_q : '0;
  assign bus.busy       = reset && (nonempty || (state_q == DRAIN));

  // FIFO shift/fill, occupancy and route/drain control.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    state_d = state_q;
    route_d = route_q;

    // Pop shifts the second entry to the head; push lands in the first free
    // slot after that shift.
    if (pop) mem0_d = mem1_q;
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) mem0_d = bus.in1_data;
      else                                                  mem1_d = bus.in1_data;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (state_q == ACTIVE) begin
      if (!match) state_d = DRAIN;
    end else begin
      if (match) begin
        state_d = ACTIVE;            // switch withdrawn, keep the old route
      end else if (count_d == 2'd0) begin
        route_d = bus.sel;
        state_d = ACTIVE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ACTIVE;
      count_q <= 2'd0;
      route_q <= 1'b0;
      mem0_q  <= '0;
      mem1_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      route_q <= route_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

endmodule

// File: tb/tb_sbox1x2_buffered.sv
// Bench for the 1-to-2 switching box: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_sbox1x2_buffered;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sbox1x2_buffered_if #(.SIZE(32)) bus ();
  sbox1x2_buffered #(.SIZE(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: token queue, current route, pending-switch flag.
  logic [31:0] q[$];
  logic        m_route = 1'b0;
  logic        m_drain = 1'b0;
  logic [31:0] log1[$];
  logic [31:0] log2[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic w, logic [31:0] d, logic s, logic f1, logic f2);
    bus.in1_write = w; bus.in1_data = d; bus.sel = s;
    bus.out1_full_n = f1; bus.out2_full_n = f2;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, cross the edge.
  task automatic cycle();
    logic e_full, e_w1, e_w2, e_busy, pop, push;
    logic [31:0] e_data;
    @(negedge clock);
    e_full = reset && !m_drain && (q.size() < 2) && (bus.sel == m_route);
    e_w1   = reset && (q.size() > 0) && !m_route;
    e_w2   = reset && (q.size() > 0) &&  m_route;
    e_busy = reset && ((q.size() > 0) || m_drain);
    e_data = (q.size() > 0) ? q[0] : 32'h0;
    vectors++;
    chk("in1_full_n", {31'b0, bus.in1_full_n}, {31'b0, e_full});
    chk("out1_write", {31'b0, bus.out1_write}, {31'b0, e_w1});
    chk("out2_write", {31'b0, bus.out2_write}, {31'b0, e_w2});
    chk("busy",       {31'b0, bus.busy},       {31'b0, e_busy});
    chk("out1_data",  bus.out1_data, e_data);
    chk("out2_data",  bus.out2_data, e_data);
    if (bus.out1_write && bus.out1_full_n) log1.push_back(bus.out1_data);
    if (bus.out2_write && bus.out2_full_n) log2.push_back(bus.out2_data);
    if (!reset) begin
      q.delete(); m_route = 1'b0; m_drain = 1'b0;
    end else begin
      pop  = (q.size() > 0) && (m_route ? bus.out2_full_n : bus.out1_full_n);
      push = bus.in1_write && e_full;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(bus.in1_data);
      if (!m_drain) begin
        if (bus.sel != m_route) m_drain = 1'b1;
      end else if (bus.sel == m_route) begin
        m_drain = 1'b0;
      end else if (q.size() == 0) begin
        m_route = bus.sel; m_drain = 1'b0;
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    // Reset, then idle with sel=0.
    reset = 1'b0;
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1);
    cycle(); cycle();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("idle_full_n", {31'b0, bus.in1_full_n}, 32'd1);

    // Streaming 0x10..0x13 back to back.
    log1.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i, 1'b0, 1'b1, 1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(); cycle();
    chk("stream_len", log1.size(), 32'd4);
    if (log1.size() == 4) chk("stream_last", log1[3], 32'h13);

    // Backpressure: two pushes fill the buffer, third is dropped.
    log1.delete();
    drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1); cycle();
    chk("bp_full_n", {31'b0, bus.in1_full_n}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(); cycle(); cycle();
    chk("bp_len", log1.size(), 32'd2);
    if (log1.size() == 2) chk("bp_second", log1[1], 32'hA1);

    // Route switch with the producer pressing 0xC0.
    log1.delete(); log2.delete();
    drive(1'b1, 32'hB0, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 32'hB1, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 32'hC0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(); cycle();
    chk("sw_out1_len", log1.size(), 32'd2);
    if (log2.size() > 0) chk("sw_out2_first", log2[0], 32'hC0);
    else chk("sw_out2_len", 32'd0, 32'd1);

    // Back to sel=0, then cancelled switch with one token buffered.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle();
    log1.delete(); log2.delete();
    drive(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1); cycle(); cycle();
    chk("cancel_out1", log1.size(), 32'd1);
    chk("cancel_out2", log2.size(), 32'd0);

    // Reset while draining a full buffer.
    drive(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    reset = 1'b0; cycle();
    reset = 1'b1;
    log1.delete(); log2.delete();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1); cycle();
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    cycle(); cycle();
    chk("rst_lost", log1.size() + log2.size(), 32'd0);

    // Random traffic with occasional route changes and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.sel = ~bus.sel;
      bus.in1_write   = $urandom_range(0, 3) != 0;
      bus.in1_data    = $urandom;
      bus.out1_full_n = $urandom_range(0, 3) != 0;
      bus.out2_full_n = $urandom_range(0, 3) != 0;
      reset = ($urandom_range(0, 63) != 0);
      cycle();
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
